booth_seq_divider: RTL and testbench
====================================

Name: booth_seq_divider

Overview:
- Sequential signed divider. It is the inverse operation of the team's combinational Booth multiplier.
- It takes a 2W-bit signed product-width dividend and a W-bit signed divisor, and returns a W-bit signed quotient and remainder.
- It uses a multi-cycle restoring algorithm on magnitudes, with a start/busy/done handshake.
- It sits beside the multiplier so a product can be divided back by one of its factors.

Parameters:
- WIDTH, 4, operand width W. The dividend is 2W bits; quotient, remainder and divisor are W bits. Legal range 2..32.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  2W  signed dividend, captured when start is accepted.
- divisor  input  W  signed divisor, captured when start is accepted.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid from this cycle onward.
- quotient  output  W  signed quotient, truncated toward zero.
- remainder  output  W  signed remainder; its sign follows the dividend.
- overflow  output  1  true quotient does not fit in W signed bits.
- div_by_zero  output  1  divisor was 0.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. While rst is high at an edge, all state returns to IDLE and busy, done, quotient, remainder, overflow and div_by_zero are all 0.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge k with divisor≠0: latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Load |dividend| as a 2W-bit unsigned value and |divisor| as W-bit unsigned. -2^(2W-1) and -2^(W-1) map to their unsigned magnitudes, with no overflow.
  - Clear the partial remainder (W+1 bits) and the iteration counter. Go to CALC; busy=1 from edge k.
- CALC: exactly 2W cycles, one quotient bit per cycle, MSB first.
  - Shift the remainder left and bring in the next dividend bit.
  - If remainder ≥ |divisor|: subtract it and set the quotient bit to 1; otherwise set it to 0.
  - The magnitude quotient is 2W bits. After 2W iterations go to FIX.
- FIX, single cycle:
  - Apply sign_q to the quotient magnitude and sign_r to the remainder magnitude. The remainder magnitude is always < 2^(W-1), so it always fits.
  - overflow = 1 when the signed quotient lies outside [-2^(W-1), 2^(W-1)-1]. In that case quotient = low W bits of the signed 2W-bit quotient.
  - Register the outputs, pulse done, drop busy, return to IDLE.
- Latency: done is high for the cycle following edge k+2W+1 (2W+2 clocks after start is accepted). busy is low in that same cycle.
- Divide by zero: start accepted with divisor=0 → skip CALC, go to FIX. Result: quotient=0, remainder=0, overflow=0, div_by_zero=1. done is pulsed after edge k+1.
- start while busy is ignored, and the operands are not re-sampled. start held high in IDLE re-triggers a new division every completion.
- Output hold: quotient, remainder, overflow and div_by_zero hold their values until the FIX of the next accepted division. They are not cleared on start.
- Reset mid-operation: the division is aborted, no done is produced, and all outputs are 0 on the next cycle.

Optional Feature:
- Macro: BOOTH_DIV_SAT_EN.
- Defined: on overflow, quotient saturates to 2^(W-1)-1 if sign_q=0, or to -2^(W-1) if sign_q=1. overflow is still asserted and remainder is unchanged.
- Undefined: on overflow, the quotient is truncated to the low W bits as above.

Test Plan:
- Reset, then dividend=-21, divisor=3, start one cycle → done 10 clocks later; quotient=-7, remainder=0, overflow=0, busy high for 9 clocks.
- dividend=11, divisor=-5 → quotient=-2, remainder=1. Then dividend=-13, divisor=4 → quotient=-3, remainder=-1.
- dividend=64, divisor=4 → overflow=1; quotient=0 without the macro, 7 with BOOTH_DIV_SAT_EN. Then dividend=-128, divisor=-1 → overflow=1; quotient=0 without the macro, 7 with it.
- divisor=0, dividend=25 → done 2 clocks after start; div_by_zero=1, quotient=0, remainder=0. The next valid division clears div_by_zero.
- start pulsed again 3 cycles into a division with different operands → ignored; the first result completes unchanged, with exactly one done.
- rst asserted 5 cycles into dividend=-8, divisor=-8 → no done; all outputs 0. A fresh start then gives quotient=1, remainder=0.

Source files
------------

// File: rtl/booth_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : booth_seq_divider
//  Purpose  : Sequential signed divider, companion to the combinational Booth
//             multiplier. Divides a 2W-bit signed dividend by a W-bit signed
//             divisor with a restoring algorithm on magnitudes, one quotient
//             bit per clock, and returns a W-bit signed quotient (truncated
//             toward zero) and a W-bit signed remainder (sign of dividend).
//  Ports    : clk          - clock, rising edge
//             rst          - synchronous active-high reset
//             start        - request a division (sampled only in IDLE)
//             dividend     - 2W-bit signed dividend
//             divisor      - W-bit signed divisor
//             busy         - division in progress
//             done         - one-cycle completion pulse
//             quotient     - W-bit signed quotient
//             remainder    - W-bit signed remainder
//             overflow     - true quotient does not fit in W signed bits
//             div_by_zero  - divisor was zero
//  Options  : BOOTH_DIV_SAT_EN - when defined, an overflowing quotient
//             saturates to the W-bit signed limit of its sign instead of
//             being truncated to the low W bits.
//  Revision : 1.0 - initial release
// ============================================================================
module booth_seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               overflow,
    output logic               div_by_zero
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int                 c_CNT_W      = $clog2(2*WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_ITER  = c_CNT_W'(2*WIDTH-1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [2*WIDTH-1:0] c_ONE_2W     = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   c_ONE_W      = {{(WIDTH-1){1'b0}}, 1'b1};
    // Largest quotient magnitudes representable in W signed bits.
    localparam logic [2*WIDTH-1:0] c_QNEG_MAX   = c_ONE_2W << (WIDTH-1);
    localparam logic [2*WIDTH-1:0] c_QPOS_MAX   = c_QNEG_MAX - c_ONE_2W;
`ifdef BOOTH_DIV_SAT_EN
    localparam logic [WIDTH-1:0]   c_SAT_POS    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   c_SAT_NEG    = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_accept;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // r_dvd starts as |dividend| and is shifted left one bit per iteration;
    // the freed LSBs collect quotient bits, so after 2W iterations it holds
    // the full 2W-bit quotient magnitude.
    logic [2*WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0]   r_dsr;
    // The partial remainder is always below |divisor| <= 2^(W-1), so W bits
    // of storage suffice; the W+1-bit working value exists only as the
    // shifted trial below.
    logic [WIDTH-1:0]   r_rem;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_dbz;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_overflow;
    logic               r_div_by_zero;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0]   w_dsr_abs;
    logic [WIDTH:0]     w_rem_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_q_trunc;
    logic [WIDTH-1:0]   w_q_out;
    logic [WIDTH-1:0]   w_r_out;

    // Two's-complement negation of the most negative value yields the same
    // bit pattern, which read as unsigned is exactly its magnitude.
    assign w_dvd_abs   = dividend[2*WIDTH-1] ? (~dividend + c_ONE_2W) : dividend;
    assign w_dsr_abs   = divisor[WIDTH-1]    ? (~divisor  + c_ONE_W)  : divisor;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    assign w_rem_trial = {r_rem, r_dvd[2*WIDTH-1]};
    assign w_ge        = (w_rem_trial >= {1'b0, r_dsr});
    assign w_rem_next  = w_ge ? WIDTH'(w_rem_trial - {1'b0, r_dsr})
                              : w_rem_trial[WIDTH-1:0];

    // A negative quotient may reach magnitude 2^(W-1); a positive one only
    // 2^(W-1)-1.
    assign w_ovf       = r_sign_q ? (r_dvd > c_QNEG_MAX) : (r_dvd > c_QPOS_MAX);

    // Low W bits of the signed quotient: negation commutes with truncation.
    assign w_q_trunc   = r_sign_q ? (~r_dvd[WIDTH-1:0] + c_ONE_W) : r_dvd[WIDTH-1:0];

`ifdef BOOTH_DIV_SAT_EN
    assign w_q_out     = w_ovf ? (r_sign_q ? c_SAT_NEG : c_SAT_POS) : w_q_trunc;
`else
    assign w_q_out     = w_q_trunc;
`endif

    assign w_r_out     = r_sign_r ? (~r_rem + c_ONE_W) : r_rem;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    // A zero divisor has nothing to iterate on.
                    w_state_next = (divisor == '0) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == c_LAST_ITER) begin
                    w_state_next = S_FIX;
                end
            end
            S_FIX: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd         <= '0;
            r_dsr         <= '0;
            r_rem         <= '0;
            r_cnt         <= '0;
            r_sign_q      <= 1'b0;
            r_sign_r      <= 1'b0;
            r_dbz         <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_overflow    <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            // busy covers every cycle the FSM spends outside IDLE.
            r_busy <= (w_state_next != S_IDLE);
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign_q <= dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
                        r_sign_r <= dividend[2*WIDTH-1];
                        r_dvd    <= w_dvd_abs;
                        r_dsr    <= w_dsr_abs;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_dbz    <= (divisor == '0);
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[2*WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_dbz) begin
                        r_quotient    <= '0;
                        r_remainder   <= '0;
                        r_overflow    <= 1'b0;
                        r_div_by_zero <= 1'b1;
                    end else begin
                        r_quotient    <= w_q_out;
                        r_remainder   <= w_r_out;
                        r_overflow    <= w_ovf;
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign overflow    = r_overflow;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_booth_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_seq_divider
//  Purpose  : Self-checking bench for booth_seq_divider (WIDTH=4). A table of
//             directed divisions with hand-computed results, plus sequences
//             for ignored start, mid-operation reset and output hold.
//             Expected quotients follow BOOTH_DIV_SAT_EN when it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_booth_seq_divider;

    localparam int W = 4;

`ifdef BOOTH_DIV_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           overflow;
    logic           div_by_zero;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] last_q;

    typedef struct {
        string          name;
        logic [2*W-1:0] dvd;
        logic [W-1:0]   dsr;
        logic [W-1:0]   q_tr;
        logic [W-1:0]   q_sat;
        logic [W-1:0]   r;
        logic           ovf;
        logic           dbz;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    booth_seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+#1 with the DUT idle.
    task automatic run_div(input vec_t v);
        logic [W-1:0] exp_q;
        int exp_lat;
        int n;
        int nbusy;
        bit seen;
        exp_q   = (v.ovf && SAT) ? v.q_sat : v.q_tr;
        exp_lat = v.dbz ? 2 : 2*W+2;
        dividend = v.dvd;
        divisor  = v.dsr;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({v.name, "/hold_on_start"}, 32'(quotient), 32'(last_q));
        chk({v.name, "/busy_after_start"}, 32'(busy), 32'd1);
        n = 1; nbusy = 0; seen = 1'b0;
        while (n < 40) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(posedge clk); #1;
            n++;
        end
        chk({v.name, "/done_seen"}, 32'(seen), 32'd1);
        chk({v.name, "/latency"}, 32'(n), 32'(exp_lat));
        chk({v.name, "/busy_cycles"}, 32'(nbusy), 32'(exp_lat-1));
        chk({v.name, "/busy_at_done"}, 32'(busy), 32'd0);
        chk({v.name, "/quotient"}, 32'(quotient), 32'(exp_q));
        chk({v.name, "/remainder"}, 32'(remainder), 32'(v.r));
        chk({v.name, "/overflow"}, 32'(overflow), 32'(v.ovf));
        chk({v.name, "/div_by_zero"}, 32'(div_by_zero), 32'(v.dbz));
        last_q = exp_q;
        @(posedge clk); #1;
        chk({v.name, "/done_pulse"}, 32'(done), 32'd0);
        chk({v.name, "/quotient_held"}, 32'(quotient), 32'(exp_q));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "/busy"}, 32'(busy), 32'd0);
        chk({tag, "/done"}, 32'(done), 32'd0);
        chk({tag, "/quotient"}, 32'(quotient), 32'd0);
        chk({tag, "/remainder"}, 32'(remainder), 32'd0);
        chk({tag, "/overflow"}, 32'(overflow), 32'd0);
        chk({tag, "/div_by_zero"}, 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        int ndone;
        vec_t v_rst;

        //                 name            dvd    dsr   q_tr  q_sat  r     ovf   dbz
        vecs[0]  = '{"neg21_by_3",     8'hEB, 4'h3, 4'h9, 4'h9, 4'h0, 1'b0, 1'b0};
        vecs[1]  = '{"p11_by_neg5",    8'h0B, 4'hB, 4'hE, 4'hE, 4'h1, 1'b0, 1'b0};
        vecs[2]  = '{"neg13_by_4",     8'hF3, 4'h4, 4'hD, 4'hD, 4'hF, 1'b0, 1'b0};
        vecs[3]  = '{"p64_by_4",       8'h40, 4'h4, 4'h0, 4'h7, 4'h0, 1'b1, 1'b0};
        vecs[4]  = '{"neg128_by_neg1", 8'h80, 4'hF, 4'h0, 4'h7, 4'h0, 1'b1, 1'b0};
        vecs[5]  = '{"p25_by_0",       8'h19, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
        vecs[6]  = '{"p7_by_2",        8'h07, 4'h2, 4'h3, 4'h3, 4'h1, 1'b0, 1'b0};
        vecs[7]  = '{"neg56_by_7",     8'hC8, 4'h7, 4'h8, 4'h8, 4'h0, 1'b0, 1'b0};
        vecs[8]  = '{"neg64_by_neg8",  8'hC0, 4'h8, 4'h8, 4'h7, 4'h0, 1'b1, 1'b0};
        vecs[9]  = '{"p63_by_neg8",    8'h3F, 4'h8, 4'h9, 4'h9, 4'h7, 1'b0, 1'b0};
        vecs[10] = '{"neg127_by_neg8", 8'h81, 4'h8, 4'hF, 4'h7, 4'h9, 1'b1, 1'b0};
        vecs[11] = '{"p127_by_neg8",   8'h7F, 4'h8, 4'h1, 4'h8, 4'h7, 1'b1, 1'b0};
        vecs[12] = '{"zero_by_5",      8'h00, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[13] = '{"neg1_by_7",      8'hFF, 4'h7, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0};
        vecs[14] = '{"neg128_by_1",    8'h80, 4'h1, 4'h0, 4'h8, 4'h0, 1'b1, 1'b0};
        vecs[15] = '{"p0_by_0",        8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        last_q = '0;

        for (int i = 0; i < 16; i++) begin
            run_div(vecs[i]);
        end

        // A second start three cycles into a division must be ignored.
        dividend = 8'hEB; divisor = 4'h3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        dividend = 8'h0B; divisor = 4'hB; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        chk("ignored_start/done_count", 32'(ndone), 32'd1);
        chk("ignored_start/quotient", 32'(quotient), 32'h9);
        chk("ignored_start/remainder", 32'(remainder), 32'h0);
        chk("ignored_start/busy", 32'(busy), 32'd0);

        // Reset five cycles into a division: no done, outputs cleared.
        dividend = 8'hF8; divisor = 4'h8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero("mid_reset");
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        chk("mid_reset/no_done", 32'(ndone), 32'd0);
        last_q = '0;

        v_rst = '{"after_reset_neg8_by_neg8", 8'hF8, 4'h8, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0};
        run_div(v_rst);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
